fwd_scoreboard: RTL

//  Parametrised forwarding/interlock unit for the in-order MIPS pipeline; replaces fixed
//  2-port, 3-source forward muxes. Tracks a STAGES-deep chain of in-flight register

---
 rtl/fwd_scoreboard_if.sv | 38 +++
 rtl/fwd_scoreboard.sv | 112 +++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_if.sv
// Signal bundle between the ID stage / pipeline controller (master) and the
// forwarding scoreboard (slave).
interface fwd_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int STAGES   = 3,
    parameter int RD_PORTS = 2
);
    logic [STAGES-1:0]          stg_en;
    logic [STAGES-1:0]          stg_flush;
    logic                       iss_valid;
    logic                       iss_wen;
    logic [ADDR_W-1:0]          iss_waddr;
    logic                       iss_load;
    logic [DATA_W-1:0]          res_in;
    logic [DATA_W-1:0]          mem_din;
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rf_data;
    logic [RD_PORTS*DATA_W-1:0] fwd_data;
    logic [RD_PORTS-1:0]        fwd_hit;
    logic                       raw_stall;
    logic                       wb_valid;
    logic                       wb_wen;
    logic [ADDR_W-1:0]          wb_addr;
    logic [DATA_W-1:0]          wb_data;

    modport master (
        output stg_en, stg_flush, iss_valid, iss_wen, iss_waddr, iss_load,
               res_in, mem_din, rd_addr, rf_data,
        input  fwd_data, fwd_hit, raw_stall, wb_valid, wb_wen, wb_addr, wb_data
    );

    modport slave (
        input  stg_en, stg_flush, iss_valid, iss_wen, iss_waddr, iss_load,
               res_in, mem_din, rd_addr, rf_data,
        output fwd_data, fwd_hit, raw_stall, wb_valid, wb_wen, wb_addr, wb_data
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/interlock unit: tracks in-flight register writers EXE..WB, resolves
// ID operand reads to the youngest matching writer and flags load-use hazards.
module fwd_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int STAGES   = 3,
    parameter int RD_PORTS = 2,
    parameter int LOAD_STG = 1
) (
    input  logic              clk,
    input  logic              rst,
    fwd_scoreboard_if.slave   bus
);
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_wen;
    logic [STAGES-1:0] r_load;
    logic [STAGES-1:0] r_rdy;
    logic [ADDR_W-1:0] r_waddr [STAGES];
    logic [DATA_W-1:0] r_data  [1:STAGES-1];

    logic [DATA_W-1:0]          w_data [STAGES];
    logic [STAGES-1:0]          w_rdy;
    logic [RD_PORTS*DATA_W-1:0] w_fwd_data;
    logic [RD_PORTS-1:0]        w_fwd_hit;
    logic                       w_stall;
    logic [ADDR_W-1:0]          w_addr;
    logic                       w_found;

    // Stage 0 readiness is stored at issue as ~load, equivalent to deriving it live.
    always_comb begin
        w_data[0] = bus.res_in;
        w_rdy[0]  = r_rdy[0];
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_data[i] = r_data[i];
            w_rdy[i]  = r_rdy[i];
            if (i == LOAD_STG && r_load[i]) begin
                w_data[i] = bus.mem_din;
                w_rdy[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_wen      <= '0;
            r_load     <= '0;
            r_rdy      <= '0;
            r_waddr[0] <= '0;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_waddr[i] <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (bus.stg_flush[0]) begin
                r_valid[0] <= 1'b0;
                r_wen[0]   <= 1'b0;
            end else if (bus.stg_en[0]) begin
                r_valid[0] <= bus.iss_valid;
                r_wen[0]   <= bus.iss_valid & bus.iss_wen;
                r_waddr[0] <= bus.iss_waddr;
                r_load[0]  <= bus.iss_load;
                r_rdy[0]   <= ~bus.iss_load;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (bus.stg_flush[i]) begin
                    r_valid[i] <= 1'b0;
                    r_wen[i]   <= 1'b0;
                end else if (bus.stg_en[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    r_wen[i]   <= r_wen[i-1];
                    r_waddr[i] <= r_waddr[i-1];
                    r_load[i]  <= r_load[i-1];
                    r_data[i]  <= w_data[i-1];
                    r_rdy[i]   <= (i > LOAD_STG) ? 1'b1 : w_rdy[i-1];
                end
            end
        end
    end

    // Lowest stage index is the youngest writer; older matches are ignored.
    always_comb begin
        w_fwd_data = bus.rf_data;
        w_fwd_hit  = '0;
        w_stall    = 1'b0;
        w_addr     = '0;
        w_found    = 1'b0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            w_addr  = bus.rd_addr[p*ADDR_W +: ADDR_W];
            w_found = 1'b0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (!w_found && r_valid[i] && r_wen[i] &&
                    r_waddr[i] == w_addr && w_addr != '0) begin
                    w_found      = 1'b1;
                    w_fwd_hit[p] = 1'b1;
                    if (w_rdy[i])
                        w_fwd_data[p*DATA_W +: DATA_W] = w_data[i];
                    else
                        w_stall = 1'b1;
                end
            end
        end
    end

    assign bus.fwd_data  = w_fwd_data;
    assign bus.fwd_hit   = w_fwd_hit;
    assign bus.raw_stall = w_stall;
    assign bus.wb_valid  = r_valid[STAGES-1];
    assign bus.wb_wen    = r_valid[STAGES-1] & r_wen[STAGES-1];
    assign bus.wb_addr   = r_waddr[STAGES-1];
    assign bus.wb_data   = w_data[STAGES-1];
endmodule
